// File: rtl/des_block_assembler_pkg.sv
// Shared DES assembler definitions: block/key widths, default word width, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_KEY_W   = 64;
  localparam int DES_WORD_W  = 32;
  localparam int DES_REC_W   = DES_BLOCK_W + DES_KEY_W;

  // Word position inside the block currently being assembled.
  typedef enum logic [1:0] {
    ST_PT_HI  = 2'd0,
    ST_PT_LO  = 2'd1,
    ST_KEY_HI = 2'd2,
    ST_KEY_LO = 2'd3
  } asm_state_t;

  // Fixed word order: plaintext high, plaintext low, key high, key low, repeat.
  function automatic asm_state_t next_state(input asm_state_t s);
    case (s)
      ST_PT_HI:  return ST_PT_LO;
      ST_PT_LO:  return ST_KEY_HI;
      ST_KEY_HI: return ST_KEY_LO;
      default:   return ST_PT_HI;
    endcase
  endfunction

endpackage

// File: rtl/des_block_assembler_if.sv
// Bundle of the inbound word stream and the outbound {plaintext, key} block stream.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready handshakes on both sides.
interface des_block_assembler_if
  import des_pkg::*;
#(
  parameter int WORD_W     = DES_WORD_W,
  parameter int FIFO_DEPTH = 2
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                   in_valid;
  logic [WORD_W-1:0]      in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [DES_BLOCK_W-1:0] out_plaintext;
  logic [DES_KEY_W-1:0]   out_key;
  logic [CNT_W-1:0]       fifo_count;

  // Word producer / DES engine side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_plaintext, out_key, fifo_count
  );

  // Assembler side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_plaintext, out_key, fifo_count
  );

endinterface

// File: rtl/des_block_assembler_fifo.sv
// Power-of-two circular buffer of assembled {plaintext, key} records.
// Latency: a pushed record is visible on rdata the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps count.
module des_block_fifo #(
  parameter int WIDTH      = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (cnt != CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && (cnt != '0);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // Storage and pointers; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/des_block_assembler.sv
// Gathers four inbound words into a {plaintext, key} block and queues it for the DES engine.
// Latency: block visible on out_* the cycle after its last word is accepted (FIFO empty).
// Backpressure: in_ready drops only when the FIFO is full; derived from registered count.
module des_block_assembler
  import des_pkg::*;
#(
  parameter int WORD_W     = DES_WORD_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  des_block_assembler_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  asm_state_t           state;
  logic [WORD_W-1:0]    pt_hi;
  logic [WORD_W-1:0]    pt_lo;
  logic [WORD_W-1:0]    key_hi;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [DES_REC_W-1:0] wdata;
  logic [DES_REC_W-1:0] rdata;
  logic [CNT_W-1:0]     count;

  // in_ready depends only on the registered occupancy, never on out_ready.
  assign bus.in_ready  = (count < CNT_W'(FIFO_DEPTH));
  assign bus.out_valid = (count != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && (state == ST_KEY_LO);
  assign pop           = bus.out_valid && bus.out_ready;

  // The final key word bypasses staging and goes straight into the record.
  assign wdata = {pt_hi, pt_lo, key_hi, bus.in_data};

  assign bus.out_plaintext = rdata[DES_REC_W-1:DES_KEY_W];
  assign bus.out_key       = rdata[DES_KEY_W-1:0];
  assign bus.fifo_count    = count;

  // Word-position FSM with staging registers; it holds whenever no word is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_PT_HI;
      pt_hi  <= '0;
      pt_lo  <= '0;
      key_hi <= '0;
    end else if (accept) begin
      case (state)
        ST_PT_HI:  pt_hi  <= bus.in_data;
        ST_PT_LO:  pt_lo  <= bus.in_data;
        ST_KEY_HI: key_hi <= bus.in_data;
        default:   ;
      endcase
      state <= next_state(state);
    end
  end

  des_block_fifo #(
    .WIDTH      (DES_REC_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count)
  );

endmodule

// File: tb/tb_des_block_assembler.sv
// Self-checking bench for des_block_assembler: vector table, corner sequences, random soak.
// Latency: n/a.
// Backpressure: exercised through out_ready stalls and random gaps.
module tb_des_block_assembler;
  import des_pkg::*;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 2;
  localparam int N_WRAP = 3325;
  localparam logic [63:0] KEY_0_7 = 64'h3031323334353637;

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [63:0]      pt;
    logic [63:0]      key;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  des_block_assembler_if #(.WORD_W(WORD_W), .FIFO_DEPTH(DEPTH)) bus();

  des_block_assembler #(.WORD_W(WORD_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [127:0] q[$];
  int cyc = 0;
  int widx = 0;
  int last_pop = -1;
  int n_pop = 0;
  bit stream_chk = 0;
  bit rand_on = 0;
  logic hold_prev = 1'b0;
  logic [127:0] prev_blk;
  logic [127:0] exp_blk;
  logic [31:0] wbuf [4];
  vec_t tbl [5];

  task automatic check_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got timeout/unexpected expected handshake", nm);
  endtask

  // Scoreboard: predicts handshakes that happen at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      widx = 0;
      hold_prev = 1'b0;
    end else begin
      check_v("fifo_count", bus.fifo_count, q.size());
      check_v("out_valid", bus.out_valid, q.size() != 0);
      check_v("in_ready", bus.in_ready, q.size() < DEPTH);
      if (hold_prev) check_v("held_block", {bus.out_plaintext, bus.out_key}, prev_blk);
      if (stream_chk) check_v("stream_count_le1", bus.fifo_count <= 1, 1);
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (q.size() == 0) begin
          fail_now("pop_without_block");
        end else begin
          exp_blk = q.pop_front();
          check_v("pop_order", {bus.out_plaintext, bus.out_key}, exp_blk);
        end
        if (stream_chk) begin
          if (last_pop >= 0) check_v("stream_interval", cyc - last_pop, 4);
          last_pop = cyc;
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_blk  = {bus.out_plaintext, bus.out_key};
      if (bus.in_valid && bus.in_ready) begin
        wbuf[widx] = bus.in_data;
        if (widx == 3) begin
          q.push_back({wbuf[0], wbuf[1], wbuf[2], wbuf[3]});
          widx = 0;
        end else begin
          widx++;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input int gap_pct);
    int budget;
    logic acc;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    budget = 0;
    forever begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) break;
      budget++;
      if (budget > 2000) begin
        fail_now("accept_timeout");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] pt, input logic [63:0] key, input int gap_pct);
    send_word(pt[63:32], gap_pct);
    send_word(pt[31:0], gap_pct);
    send_word(key[63:32], gap_pct);
    send_word(key[31:0], gap_pct);
  endtask

  task automatic drain();
    int b = 0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && b < 1000) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 1000) fail_now("drain_timeout");
  endtask

  initial begin
    logic [31:0] iv;
    tbl[0] = '{w: {32'h6B6E6F74, 32'h736C6970, 32'h72696573, 32'h6D656D6F},
               pt: 64'h6D656D6F72696573, key: 64'h736C69706B6E6F74};
    tbl[1] = '{w: {32'h0, 32'h0, 32'h0, 32'h0}, pt: 64'h0, key: 64'h0};
    tbl[2] = '{w: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
               pt: 64'hFFFFFFFFFFFFFFFF, key: 64'hFFFFFFFFFFFFFFFF};
    tbl[3] = '{w: {32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567},
               pt: 64'h0123456789ABCDEF, key: 64'hFEDCBA9876543210};
    tbl[4] = '{w: {32'h0000FFFF, 32'hFFFF0000, 32'h5A5A5A5A, 32'hA5A5A5A5},
               pt: 64'hA5A5A5A55A5A5A5A, key: 64'hFFFF00000000FFFF};

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_v("rst_in_ready", bus.in_ready, 1);
    check_v("rst_out_valid", bus.out_valid, 0);
    check_v("rst_count", bus.fifo_count, 0);
    check_v("rst_pt", bus.out_plaintext, 0);
    check_v("rst_key", bus.out_key, 0);
    check_v("rst_state", dut.state, ST_PT_HI);
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table: one block at a time, output checked one cycle after the last accept.
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send_word(tbl[i].w[k], 0);
      check_v("vec_out_valid", bus.out_valid, 1);
      check_v("vec_pt", bus.out_plaintext, tbl[i].pt);
      check_v("vec_key", bus.out_key, tbl[i].key);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check_v("vec_count_after_pop", bus.fifo_count, 0);
    end

    // Backpressure: third block is held at its first word while the FIFO is full.
    bus.out_ready = 1'b0;
    send_block(64'h1, KEY_0_7, 0);
    send_block(64'h2, KEY_0_7, 0);
    fork
      send_block(64'h3, KEY_0_7, 0);
    join_none
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_v("full_count", bus.fifo_count, 2);
    check_v("full_in_ready", bus.in_ready, 0);
    check_v("full_state_held", dut.state, ST_PT_HI);
    check_v("full_head_pt", bus.out_plaintext, 64'h1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_v("full_pop_count", bus.fifo_count, 1);
    check_v("full_pop_in_ready", bus.in_ready, 1);
    check_v("full_pop_head_pt", bus.out_plaintext, 64'h2);
    bus.out_ready = 1'b1;
    wait fork;
    drain();

    // Continuous streaming: one block every four cycles, occupancy never above one.
    last_pop = -1;
    stream_chk = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_block({32'hABCD0000, i}, KEY_0_7 ^ 64'(i), 0);
    drain();
    stream_chk = 1'b0;

    // Reset mid-operation: one block buffered, two words of the next one staged.
    bus.out_ready = 1'b0;
    send_block(64'h1111111122222222, 64'h3333333344444444, 0);
    send_word(32'hDEADBEEF, 0);
    send_word(32'hCAFEF00D, 0);
    rst = 1'b1;
    #1;
    check_v("midrst_out_valid", bus.out_valid, 0);
    check_v("midrst_count", bus.fifo_count, 0);
    check_v("midrst_pt", bus.out_plaintext, 0);
    check_v("midrst_key", bus.out_key, 0);
    check_v("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    send_block(64'h6D656D6F72696573, 64'h736C69706B6E6F74, 0);
    check_v("postrst_out_valid", bus.out_valid, 1);
    check_v("postrst_pt", bus.out_plaintext, 64'h6D656D6F72696573);
    check_v("postrst_key", bus.out_key, 64'h736C69706B6E6F74);
    drain();

    // Idle out_ready on an empty FIFO must not move anything.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check_v("idle_count", bus.fifo_count, 0);
    check_v("idle_wr_ptr", dut.u_fifo.wr_ptr, 0);
    check_v("idle_rd_ptr", dut.u_fifo.rd_ptr, 0);
    send_block(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0);
    check_v("idle_then_pt", bus.out_plaintext, 64'h0123456789ABCDEF);
    check_v("idle_then_key", bus.out_key, 64'hFEDCBA9876543210);
    drain();

    // Random soak across many pointer wraps.
    n_pop = 0;
    rand_on = 1'b1;
    fork
      while (rand_on) begin
        @(posedge clk); #1;
        bus.out_ready = ($urandom_range(3) != 0);
      end
    join_none
    for (int i = 0; i < N_WRAP; i++) begin
      iv = i;
      send_block({iv, ~iv}, {iv * 32'h9E3779B9, 32'hC0DE0000 ^ iv}, 25);
    end
    rand_on = 1'b0;
    @(posedge clk); #2;
    drain();
    check_v("wrap_pops", n_pop, N_WRAP);
    check_v("wrap_final_count", bus.fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/des_block_assembler.md
DES_BLOCK_ASSEMBLER -- requirements
Module: des_block_assembler

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of the inbound network word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of assembled blocks buffered; must be a power of two and at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  inbound word present.
REQ-006 SHALL have port in_data  input  WORD_W  inbound word.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port out_valid  output  1  an assembled block is presented to the DES engine.
REQ-009 SHALL have port out_ready  input  1  DES engine consumes the presented block.
REQ-010 SHALL have port out_plaintext  output  64  plaintext block for the DES engine.
REQ-011 SHALL have port out_key  output  64  key for the DES engine.
REQ-012 SHALL have port fifo_count  output  log2(FIFO_DEPTH)+1  number of buffered blocks.

Function
REQ-013 SHALL accept a word on every rising edge where in_valid and in_ready are both 1; no other edge accepts a word.
REQ-014 SHALL assemble each block from four accepted words in fixed order: plaintext[63:32], plaintext[31:0], key[63:32], key[31:0].
REQ-015 SHALL track word position with FSM states ST_PT_HI -> ST_PT_LO -> ST_KEY_HI -> ST_KEY_LO -> ST_PT_HI, advancing only on an accepted word.
REQ-016 SHALL hold the first three words of a block in staging registers, and SHALL write the complete 128-bit record {plaintext, key} into the FIFO on the edge that accepts the ST_KEY_LO word.
REQ-017 SHALL drive in_ready = 1 exactly when fifo_count < FIFO_DEPTH, derived from registered state only, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = 1 exactly when fifo_count > 0; out_plaintext and out_key SHALL show the head FIFO entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 SHALL pop the head entry on every edge where out_valid and out_ready are both 1.
REQ-020 Latency: a block whose last word is accepted at edge N SHALL show out_valid=1 in the cycle after edge N if the FIFO was empty.
REQ-021 Simultaneous push and pop on the same edge SHALL leave fifo_count unchanged, and both the write and read pointers SHALL advance.
REQ-022 Full: with fifo_count = FIFO_DEPTH, in_ready=0 and the FSM SHALL hold, including when a partially assembled block is staged; pop at that edge SHALL make in_ready=1 in the next cycle.
REQ-023 Empty: out_ready asserted while out_valid=0 SHALL have no effect.
REQ-024 Read and write pointers SHALL be log2(FIFO_DEPTH) bits wide and SHALL wrap modulo FIFO_DEPTH without a gap or a duplicated entry.
REQ-025 Blocks SHALL leave in strict arrival order; the FIFO SHALL never drop or reorder a block.

Reset
REQ-026 Reset SHALL force FSM to ST_PT_HI, pointers to 0, fifo_count to 0, out_valid to 0 and in_ready to 1, with staging registers, out_plaintext and out_key all 0.
REQ-027 Reset asserted mid-assembly or with buffered blocks SHALL discard all partial and buffered data; the first word accepted after reset release SHALL be treated as plaintext[63:32].

Structure
REQ-028 Shared package des_pkg SHALL hold DES_BLOCK_W=64, DES_KEY_W=64, the default WORD_W and the FSM state encodings.
REQ-029 The FIFO SHALL be a sub-module des_block_fifo (parameters WIDTH=128 and FIFO_DEPTH; ports push, pop, wdata, rdata, count), instantiated once.

Verification
REQ-030 Single block: words 0x6D656D6F, 0x72696573, 0x736C6970, 0x6B6E6F74 ("memories"/"slipknot") -> one cycle after the 4th accept, out_valid=1, out_plaintext=0x6D656D6F72696573, out_key=0x736C69706B6E6F74.
REQ-031 Backpressure: out_ready=0, stream 3 blocks (plaintexts 0x...01/02/03, key "01234567"=0x3031323334353637) -> fifo_count=2, in_ready=0 with 3rd block held at ST_PT_HI; release out_ready -> blocks appear in order 01, 02, 03.
REQ-032 Full simultaneous: FIFO full, out_ready=1 for one cycle -> count 2->1, in_ready=1 the next cycle; continuous streaming with out_ready=1 and in_valid=1 -> one block every 4 cycles, count never above 1.
REQ-033 Wrap-around: 3325 blocks (133*200/8) with random in_valid/out_ready gaps -> all ciphertext-engine inputs match the scoreboard in order, with no loss.
REQ-034 Reset mid-operation: assert reset after 2 words of a block with 1 block buffered -> out_valid=0, count=0 immediately; next 4 words form a correct block.
REQ-035 Idle out_ready: out_ready=1 with FIFO empty for 10 cycles -> count stays 0 and the pointers do not move.
